// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage between the instruction RAM and decode. Owns the
//   fetch PC and issues word reads to a synchronous RAM with a one-cycle read
//   latency. It pairs each returned word with its byte address and queues the
//   pair in a small output buffer that decode drains through a valid/ready
//   handshake. A redirect flushes the buffer and the in-flight read, then
//   restarts fetch at the new target.
//
//   Parameters
//     RESET_PC        byte address of the first fetch after reset
//     DEPTH           output buffer entries (2..8)
//
//   Ports
//     clk             rising-edge clock
//     reset           asynchronous, active-high reset
//     redirect        flush and restart fetch at redirect_target
//     redirect_target new fetch byte address (bits [1:0] ignored)
//     mem_addr        word address to RAM (fetch_pc[31:2]), always driven
//     mem_re          read request qualifying mem_addr
//     mem_dout        RAM read data, valid the cycle after mem_re
//     out_valid       out_pc/out_inst hold a fetched instruction
//     out_ready       decode accepts the head entry this cycle
//     out_pc          byte address of out_inst
//     out_inst        instruction word
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [29:0] mem_addr,
   output logic        mem_re,
   input  logic [31:0] mem_dout,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   pc_buf_q   [DEPTH];
   logic [31:0]   pc_buf_d   [DEPTH];
   logic [31:0]   inst_buf_q [DEPTH];
   logic [31:0]   inst_buf_d [DEPTH];

   logic          pop;
   logic          push;
   logic          issue;
   logic [CW:0]   occupancy;

   // The low two target bits carry no information for word-aligned fetch.
   logic          unused_target_bits;
   assign unused_target_bits = ^redirect_target[1:0];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign out_valid = (count_q != '0);
   assign out_pc    = pc_buf_q[rd_ptr_q];
   assign out_inst  = inst_buf_q[rd_ptr_q];
   assign mem_addr  = fetch_pc_q[31:2];

   assign pop  = out_valid & out_ready;
   assign push = inflight_q & ~redirect;

   // Credit check: entries held plus the read still in flight, minus the one
   // leaving this cycle, must leave room for the word this request returns.
   // The pop term makes out_ready combinationally reach mem_re.
   assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign issue     = ~reset & ~redirect & (occupancy < (CW+1)'(DEPTH));
   assign mem_re    = issue;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      pc_buf_d      = pc_buf_q;
      inst_buf_d    = inst_buf_q;

      if (redirect) begin
         // Buffered entries and the returning word are discarded; a pop in
         // this cycle has still been taken by decode.
         fetch_pc_d = {redirect_target[31:2], 2'b00};
         inflight_d = 1'b0;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (issue) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_pc_d = fetch_pc_q;
         end
         if (push) begin
            pc_buf_d[wr_ptr_q]   = inflight_pc_q;
            inst_buf_d[wr_ptr_q] = mem_dout;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_buf_q[i]   <= '0;
            inst_buf_q[i] <= '0;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         pc_buf_q      <= pc_buf_d;
         inst_buf_q    <= inst_buf_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed bench for fetch_unit. Each RAM model returns its own word address
//   as data, so every expected out_inst equals out_pc >> 2. A second instance
//   starts near the top of the address space to exercise PC wrap.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [29:0] mem_addr;
   logic        mem_re;
   logic [31:0] mem_dout;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;

   logic [29:0] w_mem_addr;
   logic        w_mem_re;
   logic [31:0] w_mem_dout;
   logic        w_out_valid;
   logic [31:0] w_out_pc;
   logic [31:0] w_out_inst;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk(clk), .reset(reset), .redirect(redirect),
      .redirect_target(redirect_target), .mem_addr(mem_addr), .mem_re(mem_re),
      .mem_dout(mem_dout), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
      .clk(clk), .reset(reset), .redirect(1'b0),
      .redirect_target(32'h0000_0000), .mem_addr(w_mem_addr), .mem_re(w_mem_re),
      .mem_dout(w_mem_dout), .out_valid(w_out_valid), .out_ready(1'b1),
      .out_pc(w_out_pc), .out_inst(w_out_inst)
   );

   // Synchronous RAMs: word at word address i holds the value i.
   always @(posedge clk) begin
      if (mem_re)   mem_dout   <= {2'b00, mem_addr};
      if (w_mem_re) w_mem_dout <= {2'b00, w_mem_addr};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] wrap_pc   [3];
   logic [31:0] wrap_inst [3];

   initial begin
      wrap_pc   = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      wrap_inst = '{32'h3FFF_FFFF, 32'h0000_0000, 32'h0000_0001};

      reset = 1'b1; redirect = 1'b0; redirect_target = '0; out_ready = 1'b1;
      #3;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_re", {31'd0, mem_re}, 32'd0);
      chk("rst_addr", {2'b00, mem_addr}, 32'd0);
      chk("rst_wrap_addr", {2'b00, w_mem_addr}, 32'h3FFF_FFFE);

      step(); step();
      reset = 1'b0;
      #1;
      chk("c0_re", {31'd0, mem_re}, 32'd1);
      chk("c0_addr", {2'b00, mem_addr}, 32'd0);
      step();
      chk("c1_valid", {31'd0, out_valid}, 32'd0);
      chk("c1_re", {31'd0, mem_re}, 32'd1);
      chk("c1_addr", {2'b00, mem_addr}, 32'd1);
      step();
      chk("c2_valid", {31'd0, out_valid}, 32'd1);
      chk("c2_pc", out_pc, 32'd0);
      chk("c2_inst", out_inst, 32'd0);
      chk("wrap_pc0", w_out_pc, 32'hFFFF_FFF8);
      chk("wrap_inst0", w_out_inst, 32'h3FFF_FFFE);

      // Sustained stream, one instruction per cycle.
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("stream_valid", {31'd0, out_valid}, 32'd1);
         chk("stream_pc", out_pc, 32'(4 * k));
         chk("stream_inst", out_inst, 32'(k));
         chk("wrap_valid", {31'd0, w_out_valid}, 32'd1);
         chk("wrap_pc", w_out_pc, wrap_pc[k-1]);
         chk("wrap_inst", w_out_inst, wrap_inst[k-1]);
      end

      // Backpressure: 12 is shown, 16 is in flight; dropping ready removes the credit.
      out_ready = 1'b0;
      #1;
      chk("bp_re_comb", {31'd0, mem_re}, 32'd0);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_pc", out_pc, 32'd12);
         chk("bp_re", {31'd0, mem_re}, 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rel_re", {31'd0, mem_re}, 32'd1);
      chk("bp_rel_addr", {2'b00, mem_addr}, 32'd5);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("bp_drain_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_drain_pc", out_pc, 32'(16 + 4 * k));
         chk("bp_drain_inst", out_inst, 32'(4 + k));
      end

      // Misaligned redirect while 28 is popped and 32 is in flight.
      redirect = 1'b1; redirect_target = 32'h0000_0043;
      #1;
      chk("rd_re", {31'd0, mem_re}, 32'd0);
      chk("rd_pop_pc", out_pc, 32'd28);
      step();
      redirect = 1'b0;
      #1;
      chk("rd1_valid", {31'd0, out_valid}, 32'd0);
      chk("rd1_re", {31'd0, mem_re}, 32'd1);
      chk("rd1_addr", {2'b00, mem_addr}, 32'h10);
      step();
      chk("rd2_valid", {31'd0, out_valid}, 32'd0);
      chk("rd2_addr", {2'b00, mem_addr}, 32'h11);
      step();
      chk("rd3_valid", {31'd0, out_valid}, 32'd1);
      chk("rd3_pc", out_pc, 32'h40);
      chk("rd3_inst", out_inst, 32'h10);
      step();
      chk("rd4_pc", out_pc, 32'h44);
      step();
      chk("rd5_pc", out_pc, 32'h48);
      out_ready = 1'b0;
      step(); step();
      chk("full_pc", out_pc, 32'h48);
      chk("full_re", {31'd0, mem_re}, 32'd0);

      // Redirect held two cycles on a full buffer; the second target wins.
      redirect = 1'b1; redirect_target = 32'h0000_0100;
      #1;
      chk("rh0_re", {31'd0, mem_re}, 32'd0);
      step();
      redirect_target = 32'h0000_0200;
      #1;
      chk("rh1_re", {31'd0, mem_re}, 32'd0);
      chk("rh1_valid", {31'd0, out_valid}, 32'd0);
      step();
      redirect = 1'b0;
      #1;
      chk("rh2_re", {31'd0, mem_re}, 32'd1);
      chk("rh2_addr", {2'b00, mem_addr}, 32'h80);
      step(); step();
      chk("rh4_valid", {31'd0, out_valid}, 32'd1);
      chk("rh4_pc", out_pc, 32'h200);
      chk("rh4_inst", out_inst, 32'h80);
      step();
      chk("hold_pc", out_pc, 32'h200);
      chk("hold_inst", out_inst, 32'h80);
      out_ready = 1'b1;
      step();
      chk("rh_next_pc", out_pc, 32'h204);

      // Asynchronous reset between edges while streaming.
      step();
      #3;
      reset = 1'b1;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_re", {31'd0, mem_re}, 32'd0);
      chk("arst_addr", {2'b00, mem_addr}, 32'd0);
      step();
      reset = 1'b0;
      #1;
      chk("arst_c0_re", {31'd0, mem_re}, 32'd1);
      chk("arst_c0_addr", {2'b00, mem_addr}, 32'd0);
      step(); step();
      chk("arst_c2_valid", {31'd0, out_valid}, 32'd1);
      chk("arst_c2_pc", out_pc, 32'd0);
      step();
      chk("arst_c3_pc", out_pc, 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
